// File: rtl/pcpi_clmul_iter.sv
// -----------------------------------------------------------------------------
// pcpi_clmul_iter
//
// Iterative carry-less multiply coprocessor for the PCPI port of the soft core.
// Decodes the Zbc clmul / clmulh instructions (and clmulr when the CLMUL_REV_EN
// macro is defined). Consumes STEP multiplier bits per cycle, so a result takes
// N = XLEN/STEP run cycles, then reports through the PCPI ready/wr handshake.
//
// Build option:
//   CLMUL_REV_EN  defined   -> funct3 010 decodes as clmulr
//                 undefined -> funct3 010 is not claimed (core traps)
//
// Parameters:
//   XLEN        operand/result width (power of two, >= 8)
//   STEP        multiplier bits per cycle (power of two, 1..XLEN)
//
// Ports:
//   clk         clock, all logic on rising edge
//   rst         synchronous active-high reset
//   pcpi_valid  core presents an instruction (held until ready or abort)
//   pcpi_insn   instruction word
//   pcpi_rs1    multiplicand
//   pcpi_rs2    multiplier
//   pcpi_wr     write pcpi_rd to rd (pulses with pcpi_ready)
//   pcpi_rd     result, holds until the next completion
//   pcpi_wait   instruction claimed, computation in progress
//   pcpi_ready  one-cycle completion pulse
//   dbg_state_o current FSM state (0 idle, 1 run, 2 done)
//
// Handshake: an instruction is claimed on the edge where pcpi_valid is high in
// IDLE and the word decodes; pcpi_valid must stay high through every RUN cycle
// (a low sample aborts silently); ready/wr pulse for exactly one cycle in DONE.
// -----------------------------------------------------------------------------
module pcpi_clmul_iter #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned STEP = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pcpi_valid,
    input  logic [31:0]     pcpi_insn,
    input  logic [XLEN-1:0] pcpi_rs1,
    input  logic [XLEN-1:0] pcpi_rs2,
    output logic            pcpi_wr,
    output logic [XLEN-1:0] pcpi_rd,
    output logic            pcpi_wait,
    output logic            pcpi_ready,
    output logic [1:0]      dbg_state_o
);

    localparam int unsigned N  = XLEN / STEP;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Result selection latched at accept time.
    typedef enum logic [1:0] {
        M_LO  = 2'd0,
        M_HI  = 2'd1,
        M_REV = 2'd2
    } mode_e;

    state_e              state_q;
    mode_e               mode_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [2*XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]     mplier_q;
    logic [CW-1:0]       cnt_q;
    logic [XLEN-1:0]     rd_q;
    logic                wr_q;
    logic                ready_q;
    logic                wait_q;

    logic [2*XLEN-1:0]   step_xor;
    logic [2*XLEN-1:0]   acc_d;
    logic [XLEN-1:0]     result_d;
    logic                insn_match;
    mode_e               mode_d;

    // Only opcode, funct3 and funct7 matter; the register fields are the core's.
    logic                unused_insn_bits;
    assign unused_insn_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

    // Decode
    always_comb begin
        insn_match = 1'b0;
        mode_d     = M_LO;
        if (pcpi_insn[6:0] == 7'b0110011 && pcpi_insn[31:25] == 7'b0000101) begin
            case (pcpi_insn[14:12])
                3'b001: begin insn_match = 1'b1; mode_d = M_LO; end
                3'b011: begin insn_match = 1'b1; mode_d = M_HI; end
`ifdef CLMUL_REV_EN
                3'b010: begin insn_match = 1'b1; mode_d = M_REV; end
`endif
                default: begin insn_match = 1'b0; mode_d = M_LO; end
            endcase
        end
    end

    // One run cycle: XOR in the STEP partial products picked by the low
    // multiplier bits. mcand_q already carries the shift from earlier cycles.
    always_comb begin
        step_xor = '0;
        for (int j = 0; j < STEP; j++) begin
            if (mplier_q[j]) begin
                step_xor = step_xor ^ (mcand_q << j);
            end
        end
        acc_d = acc_q ^ step_xor;
    end

    // Result tap from the completed product.
    always_comb begin
        result_d = acc_d[XLEN-1:0];
        case (mode_q)
            M_HI:    result_d = acc_d[2*XLEN-1:XLEN];
`ifdef CLMUL_REV_EN
            M_REV:   result_d = acc_d[2*XLEN-2:XLEN-1];
`endif
            default: result_d = acc_d[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= M_LO;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            rd_q     <= '0;
            wr_q     <= 1'b0;
            ready_q  <= 1'b0;
            wait_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    wr_q    <= 1'b0;
                    ready_q <= 1'b0;
                    if (pcpi_valid && insn_match) begin
                        state_q  <= S_RUN;
                        wait_q   <= 1'b1;
                        mode_q   <= mode_d;
                        acc_q    <= '0;
                        mcand_q  <= {{XLEN{1'b0}}, pcpi_rs1};
                        mplier_q <= pcpi_rs2;
                        cnt_q    <= '0;
                    end
                end
                S_RUN: begin
                    if (!pcpi_valid) begin
                        // Abort wins even on the last run cycle; rd is untouched.
                        state_q <= S_IDLE;
                        wait_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << STEP;
                        mplier_q <= mplier_q >> STEP;
                        if (cnt_q == LAST_CNT) begin
                            state_q <= S_DONE;
                            wait_q  <= 1'b0;
                            ready_q <= 1'b1;
                            wr_q    <= 1'b1;
                            rd_q    <= result_d;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    wr_q    <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    wr_q    <= 1'b0;
                    wait_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pcpi_wr     = wr_q;
    assign pcpi_rd     = rd_q;
    assign pcpi_wait   = wait_q;
    assign pcpi_ready  = ready_q;
    assign dbg_state_o = state_q;

endmodule
